cpu_exec_ctrl: RTL and testbench
================================

Name:
cpu_exec_ctrl

Overview:
Execution/load controller for the single-cycle MIPS core. It receives command bytes from a byte source such as a UART receiver, using a valid/ready handshake. It loads program words into instruction memory, and runs or single-steps the CPU by gating the PC advance. It stops the core when a HALT opcode is fetched. It sits between the debug byte link and the CPU top, driving the PC enable, the CPU reset and the instruction-memory write port.

Parameters:
NBITS, 32, datapath/instruction width
ADDR_W, 10, instruction-memory word address width (1024 words)
CTRLNBITS, 6, opcode field width (instr[NBITS-1:NBITS-CTRLNBITS])
HALT_OPCODE, 6'b111111, opcode that terminates execution

Ports:
i_clk  in  1  core clock
i_reset  in  1  reset, synchronous, active-low
i_cmd_data  in  8  command/data byte
i_cmd_valid  in  1  byte valid
o_cmd_ready  out  1  byte accepted when i_cmd_valid & o_cmd_ready at a rising edge
i_instr  in  NBITS  instruction currently fetched by the CPU
i_pc  in  NBITS  current CPU PC
o_pc_en  out  1  CPU may execute/advance this cycle
o_cpu_reset  out  1  active-high reset to the CPU PC
o_imem_we  out  1  instruction-memory write strobe
o_imem_addr  out  ADDR_W  write word address
o_imem_wdata  out  NBITS  write data
o_halted  out  1  high in HALT
o_state  out  3  current state code
o_cycles  out  NBITS  count of executed cycles (cycles with o_pc_en=1)

Behaviour:
- Commands:
  - 'L'=0x4C: load.
  - 'R'=0x52: run.
  - 'S'=0x53: step.
  - 'P'=0x50: pause.
  - 'C'=0x43: clear.
  - Any other byte, or any command not valid in the current state, is accepted and ignored.
- State codes: IDLE=0, LOAD_CNT=1, LOAD_DATA=2, WRITE=3, RUN=4, STEP=5, HALT=6, CLEAR=7.
- Reset (i_reset=0 at an edge):
  - State, address counter, byte index, word count, shift register and o_cycles all go to 0.
  - o_cpu_reset=1 combinationally while i_reset=0. All other outputs are 0.
- o_cmd_ready is 1 in IDLE, LOAD_CNT, LOAD_DATA, RUN and HALT; 0 in WRITE, STEP and CLEAR.
- o_cpu_reset=1 in LOAD_CNT, LOAD_DATA, WRITE and CLEAR.
- IDLE transitions: 'L' -> LOAD_CNT; 'R' -> RUN; 'S' -> STEP; 'C' -> CLEAR.
- LOAD_CNT:
  - Next byte N. If N=0, return to IDLE with no writes.
  - Otherwise latch N, clear the address and byte index, and go to LOAD_DATA.
- LOAD_DATA:
  - Bytes are assembled MSB first: word = {word[23:0], byte}.
  - On the 4th byte go to WRITE.
- WRITE (1 cycle):
  - o_imem_we=1, with o_imem_addr = current address and o_imem_wdata = assembled word.
  - Address increments modulo 2^ADDR_W.
  - If the words written equal N -> CLEAR; else -> LOAD_DATA.
- CLEAR (1 cycle): o_cycles cleared, then -> IDLE. The CPU therefore restarts at PC 0.
- Halt detect: hd = (i_instr[NBITS-1:NBITS-CTRLNBITS] == HALT_OPCODE).
- RUN:
  - o_pc_en = !hd. If hd -> HALT; the halt instruction is not executed and the PC holds.
  - 'P' accepted -> IDLE; o_pc_en is still 1 in the accepting cycle.
  - If hd and 'P' occur in the same cycle, HALT wins.
- STEP:
  - o_pc_en = !hd for exactly one cycle, then -> IDLE, or -> HALT if hd.
- HALT:
  - o_halted=1, o_pc_en=0.
  - 'C' -> CLEAR; 'L' -> LOAD_CNT; 'R', 'S' and 'P' are ignored.
- o_cycles increments on every cycle with o_pc_en=1 and saturates at all-ones.
- o_imem_we, o_imem_addr and o_imem_wdata are registered or held stable. o_imem_we is 0 outside WRITE.
- Reset mid-load: partial word and count are discarded. Words already written remain in memory.

Optional Feature:
BREAKPOINT_EN
- Defined:
  - Adds ports i_bp_addr (in, NBITS), i_bp_valid (in, 1) and o_bp_hit (out, 1).
  - In RUN, if i_bp_valid and i_pc==i_bp_addr, the controller goes to IDLE with o_pc_en=0 that cycle and pulses o_bp_hit for 1 cycle.
  - The match is ignored in the first RUN cycle after entry, so 'R' resumes past the breakpoint.
  - hd has priority over a breakpoint match.
- Undefined: the ports are absent and RUN is unaffected.

Test Plan:
1. Load: bytes 0x4C,0x02,0x20,0x08,0x00,0x05,0x01,0x09,0x50,0x20 -> two WE pulses: addr0=0x20080005, addr1=0x01095020. o_cpu_reset=1 throughout, then CLEAR and o_state=0.
2. Empty load: 0x4C,0x00 -> no o_imem_we, o_state=0 after the 2nd byte.
3. Step: i_instr=0x20080005, send 0x53 -> exactly one cycle with o_pc_en=1, o_cycles=1, back to IDLE.
4. Run to halt: send 0x52, i_instr non-halt for 3 cycles then 0xFC000000 -> o_pc_en high for 3 cycles, o_halted=1, o_cycles=3. Then 0x53 -> ignored; 0x43 -> o_cycles=0, IDLE.
5. Pause: 0x52 then 0x50 accepted on the 5th RUN cycle -> o_cycles=5, IDLE. A 0x50 coinciding with a halt opcode -> HALT.
6. Reset mid-load after 0x4C,0x01,0xAA,0xBB -> o_state=0, no WE, o_cpu_reset=1 during reset. A subsequent full load writes addr0.

Source files
------------

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: execution/load controller for the single-cycle MIPS core.
// Accepts command bytes over a valid/ready link, loads program words into
// instruction memory, and runs or single-steps the CPU by gating the PC enable.
// Optional feature macro: BREAKPOINT_EN (adds a PC breakpoint while running).
module cpu_exec_ctrl #(
  parameter int NBITS = 32,
  parameter int ADDR_W = 10,
  parameter int CTRLNBITS = 6,
  parameter logic [CTRLNBITS-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_cmd_data,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [NBITS-1:0]  i_instr,
  input  logic [NBITS-1:0]  i_pc,
`ifdef BREAKPOINT_EN
  input  logic [NBITS-1:0]  i_bp_addr,
  input  logic              i_bp_valid,
  output logic              o_bp_hit,
`endif
  output logic              o_pc_en,
  output logic              o_cpu_reset,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [NBITS-1:0]  o_imem_wdata,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [NBITS-1:0]  o_cycles
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_CNT  = 3'd1,
    LOAD_DATA = 3'd2,
    WRITE     = 3'd3,
    RUN       = 3'd4,
    STEP      = 3'd5,
    HALT      = 3'd6,
    CLEAR     = 3'd7
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [1:0]          byte_idx_reg;
  logic [7:0]          count_reg;
  logic [7:0]          written_reg;
  logic [NBITS-1:0]    shift_reg;
  logic [NBITS-1:0]    cycles_reg;
  logic                accept;
  logic                halt_detect;
  logic                pc_en;

  // Only the opcode field of the fetched instruction matters here.
  logic unused_bits;
`ifdef BREAKPOINT_EN
  logic run_first_reg;
  logic bp_hit;
  assign unused_bits = ^i_instr[NBITS-CTRLNBITS-1:0];
`else
  assign unused_bits = ^{i_pc, i_instr[NBITS-CTRLNBITS-1:0]};
`endif

  assign halt_detect = (i_instr[NBITS-1:NBITS-CTRLNBITS] == HALT_OPCODE);
  assign accept      = i_cmd_valid & o_cmd_ready;

  // Next-state and combinational outputs; link and PC are held off during reset.
  always_comb begin
    state_next  = state_reg;
    pc_en       = 1'b0;
`ifdef BREAKPOINT_EN
    bp_hit      = 1'b0;
`endif
    o_cmd_ready = i_reset && (state_reg == IDLE || state_reg == LOAD_CNT ||
                              state_reg == LOAD_DATA || state_reg == RUN ||
                              state_reg == HALT);
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (i_cmd_data)
            CMD_LOAD:  state_next = LOAD_CNT;
            CMD_RUN:   state_next = RUN;
            CMD_STEP:  state_next = STEP;
            CMD_CLEAR: state_next = CLEAR;
            default:   state_next = IDLE;
          endcase
        end
      end
      LOAD_CNT: begin
        if (accept) state_next = (i_cmd_data == 8'd0) ? IDLE : LOAD_DATA;
      end
      LOAD_DATA: begin
        if (accept && byte_idx_reg == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        state_next = (written_reg + 8'd1 == count_reg) ? CLEAR : LOAD_DATA;
      end
      RUN: begin
        if (halt_detect) begin
          state_next = HALT;
`ifdef BREAKPOINT_EN
        end else if (i_bp_valid && i_pc == i_bp_addr && !run_first_reg) begin
          bp_hit     = 1'b1;
          state_next = IDLE;
`endif
        end else begin
          pc_en = 1'b1;
          if (accept && i_cmd_data == CMD_PAUSE) state_next = IDLE;
        end
      end
      STEP: begin
        pc_en      = !halt_detect;
        state_next = halt_detect ? HALT : IDLE;
      end
      HALT: begin
        if (accept) begin
          if (i_cmd_data == CMD_CLEAR)     state_next = CLEAR;
          else if (i_cmd_data == CMD_LOAD) state_next = LOAD_CNT;
        end
      end
      CLEAR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, load datapath and executed-cycle counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      byte_idx_reg <= '0;
      count_reg    <= '0;
      written_reg  <= '0;
      shift_reg    <= '0;
      cycles_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        LOAD_CNT: begin
          if (accept && i_cmd_data != 8'd0) begin
            count_reg    <= i_cmd_data;
            addr_reg     <= '0;
            byte_idx_reg <= '0;
            written_reg  <= '0;
          end
        end
        LOAD_DATA: begin
          if (accept) begin
            shift_reg    <= {shift_reg[NBITS-9:0], i_cmd_data};
            byte_idx_reg <= byte_idx_reg + 2'd1;
          end
        end
        WRITE: begin
          addr_reg    <= addr_reg + 1'b1;
          written_reg <= written_reg + 8'd1;
        end
        default: ;
      endcase
      if (state_reg == CLEAR)
        cycles_reg <= '0;
      else if (pc_en && cycles_reg != {NBITS{1'b1}})
        cycles_reg <= cycles_reg + 1'b1;
    end
  end

`ifdef BREAKPOINT_EN
  // Marks the first RUN cycle so a resume steps past the breakpoint address.
  always_ff @(posedge i_clk) begin
    if (!i_reset) run_first_reg <= 1'b0;
    else          run_first_reg <= (state_reg != RUN);
  end
  assign o_bp_hit = bp_hit && i_reset;
`endif

  assign o_pc_en      = pc_en && i_reset;
  assign o_cpu_reset  = !i_reset || state_reg == LOAD_CNT || state_reg == LOAD_DATA ||
                        state_reg == WRITE || state_reg == CLEAR;
  assign o_imem_we    = i_reset && (state_reg == WRITE);
  assign o_imem_addr  = addr_reg;
  assign o_imem_wdata = shift_reg;
  assign o_halted     = (state_reg == HALT);
  assign o_state      = state_reg;
  assign o_cycles     = cycles_reg;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: scoreboard of expected memory writes
// plus per-scenario tasks with inline comparisons.
module tb_cpu_exec_ctrl;
  localparam int NBITS = 32;
  localparam int ADDR_W = 10;
  localparam logic [31:0] HALT_INSTR = 32'hFC000000;
  localparam logic [31:0] NOP_INSTR  = 32'h20080005;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [NBITS-1:0]  instr;
  logic [NBITS-1:0]  pc;
  logic              pc_en;
  logic              cpu_reset;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [NBITS-1:0]  imem_wdata;
  logic              halted;
  logic [2:0]        state;
  logic [NBITS-1:0]  cycles;
`ifdef BREAKPOINT_EN
  logic [NBITS-1:0]  bp_addr = '0;
  logic              bp_valid = 1'b0;
  logic              bp_hit;
`endif

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  int pc_en_count = 0;
  logic [ADDR_W+NBITS-1:0] sb[$];

  always #5 clk = ~clk;

  cpu_exec_ctrl dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cmd_data(cmd_data), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_instr(instr), .i_pc(pc),
`ifdef BREAKPOINT_EN
    .i_bp_addr(bp_addr), .i_bp_valid(bp_valid), .o_bp_hit(bp_hit),
`endif
    .o_pc_en(pc_en), .o_cpu_reset(cpu_reset), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata), .o_halted(halted),
    .o_state(state), .o_cycles(cycles)
  );

  // Scoreboard consumer: every write strobe is compared against the queue head.
  always @(negedge clk) begin
    if (pc_en) pc_en_count++;
    if (imem_we) begin
      we_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we: got addr=%0h data=%08h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [ADDR_W+NBITS-1:0] exp;
        exp = sb.pop_front();
        if ({imem_addr, imem_wdata} !== exp) begin
          errors++;
          $display("FAIL imem_write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   imem_addr, imem_wdata, exp[ADDR_W+NBITS-1:NBITS], exp[NBITS-1:0]);
        end else
          $display("write addr=%0h data=%08h ok", imem_addr, imem_wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL byte_timeout: byte %02h ready=%0b, required ready=1", b, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    $display("byte %02h sent, state=%0d", b, state);
  endtask

  task automatic expect_state(input string name, input logic [2:0] exp);
    checks++;
    if (state !== exp) begin
      errors++;
      $display("FAIL %s: state=%0d, required %0d", name, state, exp);
    end
  endtask

  task automatic expect_cycles(input string name, input logic [NBITS-1:0] exp);
    checks++;
    if (cycles !== exp) begin
      errors++;
      $display("FAIL %s: cycles=%0d, required %0d", name, cycles, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({state, cpu_reset, cmd_ready, pc_en, imem_we, halted} !== {3'd0, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d cpu_reset=%0b ready=%0b pc_en=%0b we=%0b halted=%0b, required 0 1 0 0 0 0",
               state, cpu_reset, cmd_ready, pc_en, imem_we, halted);
    end
    expect_cycles("reset_cycles", 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_reset !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cpu_reset=%0b ready=%0b, required 0 1", cpu_reset, cmd_ready);
    end
    $display("reset done");
  endtask

  task automatic test_load;
    logic [7:0] bytes [10] = '{8'h4C, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    int we_before;
    we_before = we_count;
    sb.push_back({10'd0, 32'h20080005});
    sb.push_back({10'd1, 32'h01095020});
    for (int i = 0; i < 10; i++) begin
      send_byte(bytes[i]);
      checks++;
      if (cpu_reset !== 1'b1) begin
        errors++;
        $display("FAIL load_cpu_reset: byte %0d cpu_reset=%0b, required 1", i, cpu_reset);
      end
    end
    expect_state("load_write", 3'd3);
    @(posedge clk); #1;
    expect_state("load_clear", 3'd7);
    @(posedge clk); #1;
    expect_state("load_idle", 3'd0);
    checks++;
    if (we_count - we_before != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL load_we_count: writes=%0d pending=%0d, required 2 0", we_count - we_before, sb.size());
    end
  endtask

  task automatic test_empty_load;
    int we_before;
    we_before = we_count;
    send_byte(8'h4C);
    expect_state("empty_load_cnt", 3'd1);
    send_byte(8'h00);
    expect_state("empty_load_idle", 3'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (we_count != we_before) begin
      errors++;
      $display("FAIL empty_load_we: writes=%0d, required 0", we_count - we_before);
    end
  endtask

  task automatic test_step;
    int pe_before;
    instr = NOP_INSTR;
    pe_before = pc_en_count;
    send_byte(8'h53);
    expect_state("step_state", 3'd5);
    checks++;
    if (pc_en !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL step_pc_en: pc_en=%0b ready=%0b, required 1 0", pc_en, cmd_ready);
    end
    @(posedge clk); #1;
    expect_state("step_idle", 3'd0);
    expect_cycles("step_cycles", 1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_en_count - pe_before != 1) begin
      errors++;
      $display("FAIL step_pc_en_count: pc_en cycles=%0d, required 1", pc_en_count - pe_before);
    end
  endtask

  task automatic test_run_halt;
    int pe_before;
    send_byte(8'h43);
    @(posedge clk); #1;
    expect_cycles("pre_run_clear", 0);
    instr = NOP_INSTR;
    pe_before = pc_en_count;
    send_byte(8'h52);
    expect_state("run_state", 3'd4);
    repeat (3) @(posedge clk);
    #1;
    instr = HALT_INSTR;
    #1;
    checks++;
    if (pc_en !== 1'b0) begin
      errors++;
      $display("FAIL run_halt_pc_en: pc_en=%0b, required 0", pc_en);
    end
    @(posedge clk); #1;
    expect_state("run_halt_state", 3'd6);
    checks++;
    if (halted !== 1'b1 || pc_en_count - pe_before != 3) begin
      errors++;
      $display("FAIL run_halt_flags: halted=%0b pc_en cycles=%0d, required 1 3", halted, pc_en_count - pe_before);
    end
    expect_cycles("run_halt_cycles", 3);
    send_byte(8'h53);
    expect_state("halt_ignores_step", 3'd6);
    expect_cycles("halt_step_cycles", 3);
    send_byte(8'h43);
    expect_state("halt_clear", 3'd7);
    @(posedge clk); #1;
    expect_state("halt_clear_idle", 3'd0);
    expect_cycles("halt_clear_cycles", 0);
    instr = NOP_INSTR;
  endtask

  task automatic test_pause;
    instr = NOP_INSTR;
    send_byte(8'h52);
    repeat (4) @(posedge clk);
    send_byte(8'h50);
    expect_state("pause_idle", 3'd0);
    expect_cycles("pause_cycles", 5);
    send_byte(8'h52);
    instr     = HALT_INSTR;
    cmd_data  = 8'h50;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    expect_state("pause_vs_halt", 3'd6);
    expect_cycles("pause_vs_halt_cycles", 5);
    instr = NOP_INSTR;
    send_byte(8'h43);
    @(posedge clk); #1;
    expect_state("pause_clear_idle", 3'd0);
  endtask

  task automatic test_reset_midload;
    logic [7:0] part [4] = '{8'h4C, 8'h01, 8'hAA, 8'hBB};
    logic [7:0] full [6] = '{8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    int we_before;
    we_before = we_count;
    for (int i = 0; i < 4; i++) send_byte(part[i]);
    expect_state("midload_state", 3'd2);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || cmd_ready !== 1'b0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset_comb: cpu_reset=%0b ready=%0b pc_en=%0b, required 1 0 0", cpu_reset, cmd_ready, pc_en);
    end
    @(posedge clk); #1;
    expect_state("midload_reset_state", 3'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (we_count != we_before || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL midload_no_we: writes=%0d cpu_reset=%0b, required 0 0", we_count - we_before, cpu_reset);
    end
    sb.push_back({10'd0, 32'h11223344});
    for (int i = 0; i < 6; i++) send_byte(full[i]);
    repeat (2) @(posedge clk);
    #1;
    expect_state("reload_idle", 3'd0);
    checks++;
    if (sb.size() != 0 || we_count - we_before != 1) begin
      errors++;
      $display("FAIL reload_write: writes=%0d pending=%0d, required 1 0", we_count - we_before, sb.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    instr     = NOP_INSTR;
    pc        = '0;
    test_reset();
    test_load();
    test_empty_load();
    test_step();
    test_run_halt();
    test_pause();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
